// File: rtl/vga_fb_pkg.sv
// Shared defaults and types for the double-buffered VGA framebuffer.
package vga_fb_pkg;

  localparam int unsigned H_RES_DEF   = 640;
  localparam int unsigned V_RES_DEF   = 480;
  localparam int unsigned BPC_DEF     = 2;
  localparam int unsigned OUT_BPC_DEF = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  typedef struct packed {
    logic [BPC_DEF-1:0] r;
    logic [BPC_DEF-1:0] g;
    logic [BPC_DEF-1:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_color_expand.sv
// Widens one colour channel by repeating its bit pattern from the MSB down,
// so full-scale input maps to full-scale output (2'b11 -> 4'hF).
module vga_color_expand #(
  parameter int unsigned IN_W  = 2,
  parameter int unsigned OUT_W = 4
) (
  input  logic [IN_W-1:0]  chan,
  output logic [OUT_W-1:0] chan_exp_c
);

  for (genvar i = 0; i < OUT_W; i++) begin : g_rep
    assign chan_exp_c[OUT_W-1-i] = chan[IN_W-1-(i%IN_W)];
  end

endmodule

// File: rtl/vga_fb_dbuf.sv
// Double-buffered pixel framebuffer: CPU/fill engine write the back page while
// the front page is scanned out; page flips are deferred to the start of vblank.
module vga_fb_dbuf
  import vga_fb_pkg::*;
#(
  parameter int unsigned H_RES   = H_RES_DEF,
  parameter int unsigned V_RES   = V_RES_DEF,
  parameter int unsigned BPC     = BPC_DEF,
  parameter int unsigned OUT_BPC = OUT_BPC_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pix_en,
  input  logic [9:0]             h_addr,
  input  logic [9:0]             v_addr,
  input  logic                   sel,
  input  logic                   we,
  input  logic [31:0]            addr,
  input  logic [31:0]            din,
  input  logic                   flip_req,
  input  logic                   fill_req,
  input  logic [3*BPC-1:0]       fill_color,
  output logic [3*OUT_BPC-1:0]   vga_data,
  output logic                   front_page,
  output logic                   flip_pending,
  output logic                   fill_busy,
  output logic                   fill_done
);

  localparam int unsigned DEPTH  = H_RES * V_RES;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PIX_W  = 3 * BPC;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [PIX_W-1:0] mem [2**(ADDR_W+1)];

  fill_state_t       state, state_nxt;
  logic [ADDR_W-1:0] fill_cnt, cnt_nxt;
  logic [PIX_W-1:0]  fill_color_q, color_nxt;
  logic              busy_nxt, done_nxt, fill_we_c;

  logic [ADDR_W-1:0] cpu_idx, scan_idx, wr_idx;
  logic [PIX_W-1:0]  rd_pix, wr_pix;
  logic              cpu_wr_c, wr_en_c, scan_in_range_c, vblank_c;
  logic [OUT_BPC-1:0] r_exp, g_exp, b_exp;
  logic              unused_bits;

  assign unused_bits = ^{addr[31:ADDR_W], din[31:PIX_W]};

  // Bus decode; out-of-range pixel indices are dropped and do not stall the fill
  assign cpu_idx  = addr[ADDR_W-1:0];
  assign cpu_wr_c = sel & we & (32'(cpu_idx) < DEPTH);

  assign scan_in_range_c = (32'(h_addr) < H_RES) && (32'(v_addr) < V_RES);
  assign scan_idx        = ADDR_W'(32'(v_addr) * H_RES + 32'(h_addr));
  assign vblank_c        = pix_en && (h_addr == '0) && (32'(v_addr) == V_RES) && !fill_busy;

  // Single write port shared by CPU and fill engine; CPU has priority
  assign wr_en_c = cpu_wr_c | fill_we_c;
  assign wr_idx  = cpu_wr_c ? cpu_idx : fill_cnt;
  assign wr_pix  = cpu_wr_c ? din[PIX_W-1:0] : fill_color_q;

  always_ff @(posedge clock) begin
    if (wr_en_c) mem[{~front_page, wr_idx}] <= wr_pix;
  end

  assign rd_pix = mem[{front_page, scan_idx}];

  vga_color_expand #(.IN_W(BPC), .OUT_W(OUT_BPC)) u_exp_r (
    .chan(rd_pix[3*BPC-1:2*BPC]), .chan_exp_c(r_exp));
  vga_color_expand #(.IN_W(BPC), .OUT_W(OUT_BPC)) u_exp_g (
    .chan(rd_pix[2*BPC-1:BPC]),   .chan_exp_c(g_exp));
  vga_color_expand #(.IN_W(BPC), .OUT_W(OUT_BPC)) u_exp_b (
    .chan(rd_pix[BPC-1:0]),       .chan_exp_c(b_exp));

  // Scan-out register and page-flip control
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vga_data     <= '0;
      front_page   <= 1'b0;
      flip_pending <= 1'b0;
    end else begin
      if (pix_en) vga_data <= scan_in_range_c ? {r_exp, g_exp, b_exp} : '0;
      if (flip_pending && vblank_c) begin
        front_page   <= ~front_page;
        flip_pending <= 1'b0;
      end else if (flip_req) begin
        flip_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      fill_cnt     <= '0;
      fill_color_q <= '0;
      fill_busy    <= 1'b0;
      fill_done    <= 1'b0;
    end else begin
      state        <= state_nxt;
      fill_cnt     <= cnt_nxt;
      fill_color_q <= color_nxt;
      fill_busy    <= busy_nxt;
      fill_done    <= done_nxt;
    end
  end

  // Fill engine: one back-page word per cycle the CPU leaves the port free
  always_comb begin
    state_nxt = state;
    cnt_nxt   = fill_cnt;
    color_nxt = fill_color_q;
    busy_nxt  = fill_busy;
    done_nxt  = 1'b0;
    fill_we_c = 1'b0;
    case (state)
      IDLE: begin
        if (fill_req) begin
          color_nxt = fill_color;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        if (!cpu_wr_c) begin
          fill_we_c = 1'b1;
          if (fill_cnt == LAST_IDX) begin
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = fill_cnt + ADDR_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vga_fb_dbuf.sv
// Scoreboard bench for vga_fb_dbuf on a reduced 20x6 frame.
module tb_vga_fb_dbuf;
  import vga_fb_pkg::*;

  localparam int unsigned HR    = 20;
  localparam int unsigned VR    = 6;
  localparam int unsigned DEPTH = HR * VR;

  logic        clock;
  logic        reset;
  logic        pix_en;
  logic [9:0]  h_addr, v_addr;
  logic        sel, we;
  logic [31:0] addr, din;
  logic        flip_req, fill_req;
  logic [5:0]  fill_color;
  logic [11:0] vga_data;
  logic        front_page, flip_pending, fill_busy, fill_done;

  vga_fb_dbuf #(.H_RES(HR), .V_RES(VR), .BPC(2), .OUT_BPC(4)) dut (
    .clock(clock), .reset(reset), .pix_en(pix_en), .h_addr(h_addr), .v_addr(v_addr),
    .sel(sel), .we(we), .addr(addr), .din(din), .flip_req(flip_req),
    .fill_req(fill_req), .fill_color(fill_color), .vga_data(vga_data),
    .front_page(front_page), .flip_pending(flip_pending), .fill_busy(fill_busy),
    .fill_done(fill_done));

  typedef struct {
    int          idx;
    logic [11:0] val;
  } scan_exp_t;

  scan_exp_t scan_q[$];
  int        done_q[$];
  int        checks = 0;
  int        errors = 0;
  int        cyc = 0;
  logic      chk_scan = 1'b0;
  logic      scan_d = 1'b0;
  scan_exp_t mon_e;
  int        mon_d;
  rgb_t      pix;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc    <= cyc + 1;
    scan_d <= chk_scan;
  end

  // Monitor: pops an expected word whenever a checked scan or fill_done appears
  always @(negedge clock) begin
    if (scan_d) begin
      checks++;
      if (scan_q.size() == 0) begin
        errors++;
        $display("FAIL scan_unexpected: vga_data=%h with nothing expected", vga_data);
      end else begin
        mon_e = scan_q.pop_front();
        if (vga_data !== mon_e.val) begin
          errors++;
          $display("FAIL scan idx %0d: got %h expected %h", mon_e.idx, vga_data, mon_e.val);
        end
      end
    end
    if (fill_done !== 1'b0) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL fill_done_unexpected: fill_done=%b at cycle %0d", fill_done, cyc);
      end else begin
        mon_d = done_q.pop_front();
        if (cyc != mon_d) begin
          errors++;
          $display("FAIL fill_done_cycle: got cycle %0d expected %0d", cyc, mon_d);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cpu_write(input int idx, input logic [5:0] px);
    sel = 1'b1; we = 1'b1; addr = 32'(idx); din = 32'(px);
    tick();
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic start_fill(input logic [5:0] c, input int extra);
    fill_color = c; fill_req = 1'b1;
    done_q.push_back(cyc + 1 + int'(DEPTH) + extra);
    tick();
    fill_req = 1'b0;
  endtask

  task automatic scan(input int x, input int y, input logic [11:0] exp);
    scan_exp_t e;
    e.idx = y * int'(HR) + x;
    e.val = exp;
    scan_q.push_back(e);
    pix_en = 1'b1; h_addr = 10'(x); v_addr = 10'(y); chk_scan = 1'b1;
    tick();
    pix_en = 1'b0; chk_scan = 1'b0;
  endtask

  task automatic vblank();
    pix_en = 1'b1; h_addr = '0; v_addr = 10'(VR);
    tick();
    pix_en = 1'b0;
  endtask

  task automatic pulse_flip();
    flip_req = 1'b1;
    tick();
    flip_req = 1'b0;
  endtask

  task automatic wait_fill_idle(input string name);
    int n = 0;
    while (fill_busy !== 1'b0 && n < 1000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL %s: fill_busy still %b after %0d cycles, required 0", name, fill_busy, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; pix_en = 1'b0; h_addr = '0; v_addr = '0;
    sel = 1'b0; we = 1'b0; addr = '0; din = '0;
    flip_req = 1'b0; fill_req = 1'b0; fill_color = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // 1: reset asserted mid-fill aborts it
    fill_color = 6'h3F; fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
    repeat (10) tick();
    check("t1_busy_before_reset", 32'(fill_busy), 32'd1);
    reset = 1'b0;
    #1;
    check("t1_rst_vga_data", 32'(vga_data), 32'd0);
    check("t1_rst_front_page", 32'(front_page), 32'd0);
    check("t1_rst_flip_pending", 32'(flip_pending), 32'd0);
    check("t1_rst_fill_busy", 32'(fill_busy), 32'd0);
    check("t1_rst_fill_done", 32'(fill_done), 32'd0);
    tick();
    reset = 1'b1;
    repeat (DEPTH + 5) tick();
    check("t1_idle_after_reset", 32'(fill_busy), 32'd0);

    // 2: write back page, flip at vblank, scan the pixel
    check("t2_front_initial", 32'(front_page), 32'd0);
    pix = '{r: 2'b11, g: 2'b01, b: 2'b10};
    cpu_write(HR + 1, pix);
    pulse_flip();
    check("t2_pending_set", 32'(flip_pending), 32'd1);
    scan(1, VR, 12'h000);
    check("t2_no_flip_h1", 32'(front_page), 32'd0);
    vblank();
    check("t2_front_flipped", 32'(front_page), 32'd1);
    check("t2_pending_clear", 32'(flip_pending), 32'd0);
    scan(1, 1, 12'hF5A);
    h_addr = 10'd700;
    tick();
    check("t2_hold_no_pix_en", 32'(vga_data), 32'hF5A);

    // 3: unobstructed fill of page 0, then show it and scan every pixel
    start_fill(6'b010101, 0);
    check("t3_busy", 32'(fill_busy), 32'd1);
    wait_fill_idle("t3_fill_timeout");
    pulse_flip();
    vblank();
    check("t3_front_page0", 32'(front_page), 32'd0);
    for (int y = 0; y < int'(VR); y++)
      for (int x = 0; x < int'(HR); x++)
        scan(x, y, 12'h555);

    // 4: CPU write during fill wins and delays completion by one cycle
    start_fill(6'b101010, 1);
    repeat (3) tick();
    cpu_write(1, 6'b111111);
    wait_fill_idle("t4_fill_timeout");
    pulse_flip();
    vblank();
    check("t4_front_page1", 32'(front_page), 32'd1);
    scan(0, 0, 12'hAAA);
    scan(1, 0, 12'hFFF);
    scan(2, 0, 12'hAAA);
    scan(HR - 1, VR - 1, 12'hAAA);

    // 5: two flip requests during fill give a single deferred flip
    start_fill(6'b000011, 0);
    tick();
    pulse_flip();
    tick();
    pulse_flip();
    check("t5_pending", 32'(flip_pending), 32'd1);
    vblank();
    check("t5_blocked_front", 32'(front_page), 32'd1);
    check("t5_blocked_pending", 32'(flip_pending), 32'd1);
    wait_fill_idle("t5_fill_timeout");
    check("t5_pending_after_fill", 32'(flip_pending), 32'd1);
    vblank();
    check("t5_front_flipped", 32'(front_page), 32'd0);
    check("t5_pending_clear", 32'(flip_pending), 32'd0);
    vblank();
    check("t5_single_flip", 32'(front_page), 32'd0);
    scan(0, 0, 12'h00F);
    scan(5, 3, 12'h00F);

    // 6: out-of-range write and scan, back-page isolation
    cpu_write(DEPTH, 6'b111111);
    cpu_write(0, 6'b111111);
    scan(0, 0, 12'h00F);
    scan(700, 0, 12'h000);
    scan(HR - 1, VR - 1, 12'h00F);
    scan(HR, 0, 12'h000);
    scan(3, VR, 12'h000);
    check("t6_front_unchanged", 32'(front_page), 32'd0);

    repeat (3) tick();
    checks++;
    if (scan_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d scans and %0d fill_done left, required 0",
               scan_q.size(), done_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
